panel_scan_controller: RTL

Sequencer for the LED panel's pixel memory read side. Walks the two 256x16 pixel RAM blocks (top half, bottom half) row by row and bit plane by bit plane. Drives the HUB75 shift/latch/blank/row-address pins with binary-coded modulation, so that RGB555 pixel words become perceived brightness. Sits between the pixel RAM blocks and the panel pins; the frame writer uses its frame-done pulse to schedule updates.

---
 rtl/panel_pkg.sv | 30 +++
 rtl/panel_scan_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/panel_pkg.sv
// Shared definitions for the HUB75 panel scan path: FSM state encoding,
// panel geometry and RGB555 field offsets.
package panel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_CLK,
    S_BLANK,
    S_LATCH,
    S_SHOW
  } state_t;

  localparam int PANEL_COLS   = 32;
  localparam int PANEL_ROWS   = 8;
  localparam int PANEL_PLANES = 5;

  localparam int R_LSB = 10;
  localparam int G_LSB = 5;
  localparam int B_LSB = 0;

  // Pick the {R,G,B} bits of one bit plane out of an RGB555 word (bit 15 ignored).
  function automatic logic [2:0] plane_rgb(input logic [15:0] px, input logic [2:0] plane);
    logic [3:0] p4;
    p4 = {1'b0, plane};
    return {px[4'(R_LSB) + p4], px[4'(G_LSB) + p4], px[4'(B_LSB) + p4]};
  endfunction

endpackage

// File: rtl/panel_scan_controller.sv
// HUB75 scan sequencer: walks both pixel RAM halves row by row and bit plane
// by bit plane, shifting one column per three cycles and showing each plane
// for SHOW_BASE<<plane cycles (binary-coded modulation).
// Optional build macro: PANEL_SCAN_BRIGHTNESS_EN adds i_brightness, which
// scales the lit portion of every show window without changing its length.
module panel_scan_controller
  import panel_pkg::*;
#(
  parameter int SHOW_BASE = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
`ifdef PANEL_SCAN_BRIGHTNESS_EN
  input  logic [7:0]  i_brightness,
`endif
  output logic [7:0]  o_ram_addr,
  output logic        o_ram_re,
  input  logic [15:0] i_ram_top_data,
  input  logic [15:0] i_ram_bot_data,
  output logic        o_r0,
  output logic        o_g0,
  output logic        o_b0,
  output logic        o_r1,
  output logic        o_g1,
  output logic        o_b1,
  output logic        o_sclk,
  output logic        o_lat,
  output logic        o_oe_n,
  output logic [2:0]  o_row,
  output logic        o_frame_done
);

  localparam logic [4:0] LAST_COL   = 5'(PANEL_COLS - 1);
  localparam logic [2:0] LAST_PLANE = 3'(PANEL_PLANES - 1);
  localparam logic [2:0] LAST_ROW   = 3'(PANEL_ROWS - 1);

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [2:0]  plane_q, plane_d;
  logic [2:0]  row_q, row_d;
  logic [15:0] show_cnt_q, show_cnt_d;
  logic [7:0]  ram_addr_q, ram_addr_d;
  logic        ram_re_q, ram_re_d;
  logic [2:0]  top_rgb_q, top_rgb_d;
  logic [2:0]  bot_rgb_q, bot_rgb_d;
  logic        sclk_q, sclk_d;
  logic        lat_q, lat_d;
  logic        oe_n_q, oe_n_d;
  logic [2:0]  row_out_q, row_out_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] show_len;

  assign show_len = 16'(SHOW_BASE) << plane_q;

`ifdef PANEL_SCAN_BRIGHTNESS_EN
  // Lit cycles per show window: (show_len * brightness) >> 8.
  logic [15:0] on_cnt_q, on_cnt_d;
  logic [15:0] on_len;
  logic [7:0]  on_frac_unused;
  assign {on_len, on_frac_unused} = 24'(show_len) * 24'(i_brightness);
`endif

  // Next-state and next-output computation; outputs are derived from the
  // state being entered so every pin is driven straight from a flop.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    plane_d      = plane_q;
    row_d        = row_q;
    show_cnt_d   = show_cnt_q;
    top_rgb_d    = top_rgb_q;
    bot_rgb_d    = bot_rgb_q;
    frame_done_d = 1'b0;
`ifdef PANEL_SCAN_BRIGHTNESS_EN
    on_cnt_d     = on_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d = S_FETCH;
          col_d   = '0;
          plane_d = '0;
          row_d   = '0;
        end
      end
      S_FETCH: state_d = S_DATA;
      S_DATA: begin
        // RAM data for the address issued in S_FETCH is valid now.
        state_d   = S_CLK;
        top_rgb_d = plane_rgb(i_ram_top_data, plane_q);
        bot_rgb_d = plane_rgb(i_ram_bot_data, plane_q);
      end
      S_CLK: begin
        col_d   = col_q + 5'd1;  // wraps to 0 after the last column
        state_d = (col_q == LAST_COL) ? S_BLANK : S_FETCH;
      end
      S_BLANK: state_d = S_LATCH;
      S_LATCH: begin
        state_d    = S_SHOW;
        show_cnt_d = show_len;
`ifdef PANEL_SCAN_BRIGHTNESS_EN
        on_cnt_d   = on_len;
`endif
      end
      S_SHOW: begin
        // show_cnt_q counts the remaining show cycles including this one.
        if (show_cnt_q <= 16'd1) begin
          if (plane_q != LAST_PLANE) begin
            plane_d = plane_q + 3'd1;
            state_d = S_FETCH;
          end else if (row_q != LAST_ROW) begin
            plane_d = '0;
            row_d   = row_q + 3'd1;
            state_d = S_FETCH;
          end else begin
            plane_d      = '0;
            row_d        = '0;
            frame_done_d = 1'b1;
            state_d      = i_enable ? S_FETCH : S_IDLE;
          end
        end else begin
          show_cnt_d = show_cnt_q - 16'd1;
        end
`ifdef PANEL_SCAN_BRIGHTNESS_EN
        if (on_cnt_q != 16'd0) on_cnt_d = on_cnt_q - 16'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    ram_re_d   = (state_d == S_FETCH);
    ram_addr_d = ram_re_d ? {row_d, col_d} : ram_addr_q;
    sclk_d     = (state_d == S_CLK);
    lat_d      = (state_d == S_LATCH);
    row_out_d  = lat_d ? row_d : row_out_q;
`ifdef PANEL_SCAN_BRIGHTNESS_EN
    oe_n_d     = !((state_d == S_SHOW) && (on_cnt_d != 16'd0));
`else
    oe_n_d     = (state_d != S_SHOW);
`endif
  end

  // State, counters and all panel/RAM outputs; reset forces pins safe (blanked).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      plane_q      <= '0;
      row_q        <= '0;
      show_cnt_q   <= '0;
      ram_addr_q   <= '0;
      ram_re_q     <= 1'b0;
      top_rgb_q    <= '0;
      bot_rgb_q    <= '0;
      sclk_q       <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      row_out_q    <= '0;
      frame_done_q <= 1'b0;
`ifdef PANEL_SCAN_BRIGHTNESS_EN
      on_cnt_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      plane_q      <= plane_d;
      row_q        <= row_d;
      show_cnt_q   <= show_cnt_d;
      ram_addr_q   <= ram_addr_d;
      ram_re_q     <= ram_re_d;
      top_rgb_q    <= top_rgb_d;
      bot_rgb_q    <= bot_rgb_d;
      sclk_q       <= sclk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      row_out_q    <= row_out_d;
      frame_done_q <= frame_done_d;
`ifdef PANEL_SCAN_BRIGHTNESS_EN
      on_cnt_q     <= on_cnt_d;
`endif
    end
  end

  assign o_ram_addr   = ram_addr_q;
  assign o_ram_re     = ram_re_q;
  assign {o_r0, o_g0, o_b0} = top_rgb_q;
  assign {o_r1, o_g1, o_b1} = bot_rgb_q;
  assign o_sclk       = sclk_q;
  assign o_lat        = lat_q;
  assign o_oe_n       = oe_n_q;
  assign o_row        = row_out_q;
  assign o_frame_done = frame_done_q;

endmodule
